// File: rtl/control_unit_mc.sv
// Multi-cycle registered control unit: decodes the header into datapath controls,
// stalls fetch for PAU ops and handshakes pixel-port ops with a timeout.
// Ports: clk, rst_n (async, active-low); InstHeader/InstValid from fetch;
// PixelReady from the pixel port; Stall to fetch; CtrlValid, PxReq,
// PxTimeout (sticky); registered datapath controls (RnSrc .. MemToReg).
module control_unit_mc #(
  parameter int HDR_W      = 10,
  parameter int ALUCTRL_W  = 4,
  parameter int COND_W     = 3,
  parameter int PAU_LAT    = 4,
  parameter int PX_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HDR_W-1:0]     InstHeader,
  input  logic                 InstValid,
  input  logic                 PixelReady,
  output logic                 Stall,
  output logic                 CtrlValid,
  output logic                 PxReq,
  output logic                 PxTimeout,
  output logic                 RnSrc,
  output logic                 ImmSrc,
  output logic                 RsSrc,
  output logic                 ResultSrc,
  output logic                 IOFlag,
  output logic                 PAUOp,
  output logic                 ImmExt,
  output logic                 FlagWrite,
  output logic                 ALUSrc,
  output logic                 BranchInst,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 MemPWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [COND_W-1:0]    CondFlag,
  output logic [1:0]           MemToReg
);

  localparam int PAU_W = (PAU_LAT < 2) ? 1 : $clog2(PAU_LAT);
  localparam int PX_W  = $clog2(PX_TIMEOUT + 1);
  localparam int PAU_LD = (PAU_LAT > 1) ? PAU_LAT - 2 : 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAU_BUSY = 2'd1,
    PX_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 rnsrc;
    logic                 immsrc;
    logic                 rssrc;
    logic                 resultsrc;
    logic                 ioflag;
    logic                 pauop;
    logic                 immext;
    logic                 flagwrite;
    logic                 alusrc;
    logic                 branchinst;
    logic                 memwrite;
    logic                 regwrite;
    logic                 mempwrite;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic [COND_W-1:0]    cond;
    logic [1:0]           memtoreg;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [HDR_W-1:0] h);
    ctrl_t c;
    c = '0;
    case (h[6:5])
      2'b00: begin
        if (h[4]) begin
          case (h[3:0])
            4'd1, 4'd2, 4'd3: begin
              c.immext   = 1'b1;
              c.regwrite = 1'b1;
              c.alusrc   = 1'b1;
              c.memtoreg = 2'd1;
              case (h[3:0])
                4'd1:    c.aluctrl = ALUCTRL_W'(2);
                4'd2:    c.aluctrl = ALUCTRL_W'(1);
                default: c.aluctrl = ALUCTRL_W'(7);
              endcase
            end
            4'd7: begin
              c.rnsrc    = 1'b1;
              c.immext   = 1'b1;
              c.alusrc   = 1'b1;
              c.aluctrl  = ALUCTRL_W'(2);
              c.memtoreg = 2'd1;
            end
            default: c = '0;
          endcase
        end else begin
          case (h[3:0])
            4'd1: begin
              c.regwrite = 1'b1;
              c.aluctrl  = ALUCTRL_W'(2);
              c.memtoreg = 2'd1;
            end
            4'd2: begin
              c.regwrite = 1'b1;
              c.aluctrl  = ALUCTRL_W'(1);
              c.memtoreg = 2'd1;
            end
            4'd7: begin
              c.rssrc     = 1'b1;
              c.flagwrite = 1'b1;
              c.aluctrl   = ALUCTRL_W'(2);
            end
            4'd3: begin
              c.regwrite = 1'b1;
              c.rssrc    = 1'b1;
              c.aluctrl  = ALUCTRL_W'(8);
              c.memtoreg = 2'd1;
            end
            4'd10, 4'd11: begin
              c.regwrite  = 1'b1;
              c.resultsrc = 1'b1;
              c.memtoreg  = 2'd1;
              c.pauop     = h[0];
            end
            default: c = '0;
          endcase
        end
      end
      2'b01: begin
        case (h[4:3])
          2'b00: begin
            c.immext   = 1'b1;
            c.rssrc    = 1'b1;
            c.alusrc   = 1'b1;
            c.aluctrl  = ALUCTRL_W'(1);
            c.memwrite = 1'b1;
          end
          2'b11: begin
            c.immext   = 1'b1;
            c.rssrc    = 1'b1;
            c.alusrc   = 1'b1;
            c.aluctrl  = ALUCTRL_W'(1);
            c.regwrite = 1'b1;
          end
          2'b01: begin
            c.ioflag   = 1'b1;
            c.regwrite = 1'b1;
            c.memtoreg = 2'd2;
          end
          default: begin
            c.ioflag    = 1'b1;
            c.mempwrite = 1'b1;
          end
        endcase
      end
      2'b10: begin
        c.immsrc     = 1'b1;
        c.alusrc     = 1'b1;
        c.branchinst = 1'b1;
        c.aluctrl    = ALUCTRL_W'(7);
        c.memtoreg   = 2'd1;
        c.cond       = h[6+COND_W:7];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [PAU_W-1:0]  pau_q, pau_d;
  logic [PX_W-1:0]   px_q, px_d;
  ctrl_t             ctrl_q, ctrl_d, dec;
  logic              cv_q, cv_d;
  logic              req_q, req_d;
  logic              to_q, to_d;
  logic              is_pau, is_px;

  assign dec    = decode(InstHeader);
  // Multi-cycle PAU only when the latency exceeds the normal issue slot.
  assign is_pau = (InstHeader[6:4] == 3'b000) &&
                  (InstHeader[3:1] == 3'b101) &&
                  (PAU_LAT > 1);
  assign is_px  = (InstHeader[6:5] == 2'b01) &&
                  (InstHeader[4] ^ InstHeader[3]);

  always_comb begin
    state_d = state_q;
    pau_d   = pau_q;
    px_d    = px_q;
    ctrl_d  = ctrl_q;
    cv_d    = 1'b0;
    req_d   = req_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (InstValid) begin
          ctrl_d = dec;
          unique case (1'b1)
            is_px: begin
              req_d   = 1'b1;
              px_d    = PX_W'(PX_TIMEOUT - 1);
              state_d = PX_WAIT;
            end
            is_pau: begin
              pau_d   = PAU_W'(PAU_LD);
              state_d = PAU_BUSY;
            end
            default: cv_d = 1'b1;
          endcase
        end
      end
      PAU_BUSY: begin
        if (pau_q != '0) begin
          pau_d = pau_q - 1'b1;
        end else begin
          cv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      PX_WAIT: begin
        if (PixelReady) begin
          req_d   = 1'b0;
          cv_d    = 1'b1;
          state_d = IDLE;
        end else if (px_q == '0) begin
          // Timed out: report the op but squash its writes.
          req_d            = 1'b0;
          to_d             = 1'b1;
          cv_d             = 1'b1;
          ctrl_d.regwrite  = 1'b0;
          ctrl_d.mempwrite = 1'b0;
          state_d          = IDLE;
        end else begin
          px_d = px_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pau_q   <= '0;
      px_q    <= '0;
      ctrl_q  <= '0;
      cv_q    <= 1'b0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pau_q   <= pau_d;
      px_q    <= px_d;
      ctrl_q  <= ctrl_d;
      cv_q    <= cv_d;
      req_q   <= req_d;
      to_q    <= to_d;
    end
  end

  assign Stall      = (state_q != IDLE);
  assign CtrlValid  = cv_q;
  assign PxReq      = req_q;
  assign PxTimeout  = to_q;
  assign RnSrc      = ctrl_q.rnsrc;
  assign ImmSrc     = ctrl_q.immsrc;
  assign RsSrc      = ctrl_q.rssrc;
  assign ResultSrc  = ctrl_q.resultsrc;
  assign IOFlag     = ctrl_q.ioflag;
  assign PAUOp      = ctrl_q.pauop;
  assign ImmExt     = ctrl_q.immext;
  assign FlagWrite  = ctrl_q.flagwrite;
  assign ALUSrc     = ctrl_q.alusrc;
  assign BranchInst = ctrl_q.branchinst;
  assign MemWrite   = ctrl_q.memwrite;
  assign RegWrite   = ctrl_q.regwrite;
  assign MemPWrite  = ctrl_q.mempwrite;
  assign ALUControl = ctrl_q.aluctrl;
  assign CondFlag   = ctrl_q.cond;
  assign MemToReg   = ctrl_q.memtoreg;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: expected control words are queued
// at issue and compared (value and cycle) when CtrlValid pulses.
module tb_control_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] InstHeader = '0;
  logic       InstValid = 1'b0;
  logic       PixelReady = 1'b0;
  logic       Stall, CtrlValid, PxReq, PxTimeout;
  logic       RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt;
  logic       FlagWrite, ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite;
  logic [3:0] ALUControl;
  logic [2:0] CondFlag;
  logic [1:0] MemToReg;

  control_unit_mc dut (
    .clk(clk), .rst_n(rst_n),
    .InstHeader(InstHeader), .InstValid(InstValid),
    .PixelReady(PixelReady), .Stall(Stall),
    .CtrlValid(CtrlValid), .PxReq(PxReq), .PxTimeout(PxTimeout),
    .RnSrc(RnSrc), .ImmSrc(ImmSrc), .RsSrc(RsSrc),
    .ResultSrc(ResultSrc), .IOFlag(IOFlag), .PAUOp(PAUOp),
    .ImmExt(ImmExt), .FlagWrite(FlagWrite), .ALUSrc(ALUSrc),
    .BranchInst(BranchInst), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemPWrite(MemPWrite),
    .ALUControl(ALUControl), .CondFlag(CondFlag),
    .MemToReg(MemToReg)
  );

  always #5 clk = ~clk;

  localparam int F_RN  = 1 << 12;
  localparam int F_IS  = 1 << 11;
  localparam int F_RS  = 1 << 10;
  localparam int F_RES = 1 << 9;
  localparam int F_IO  = 1 << 8;
  localparam int F_PAU = 1 << 7;
  localparam int F_IE  = 1 << 6;
  localparam int F_FW  = 1 << 5;
  localparam int F_AS  = 1 << 4;
  localparam int F_BR  = 1 << 3;
  localparam int F_MW  = 1 << 2;
  localparam int F_RW  = 1 << 1;
  localparam int F_PW  = 1 << 0;

  typedef struct {
    logic [21:0] v;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  logic [21:0] obs;

  assign obs = {RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt,
                FlagWrite, ALUSrc, BranchInst, MemWrite, RegWrite,
                MemPWrite, ALUControl, CondFlag, MemToReg};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] mk(input int f, input int alu,
                                     input int cnd, input int m2r);
    return {f[12:0], alu[3:0], cnd[2:0], m2r[1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && CtrlValid) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ctrl", 32'(obs), 32'(e.v));
        chk("latency", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Present a header for one acceptance cycle; optionally queue its result.
  task automatic issue(input logic [9:0] h, input int lat,
                       input logic [21:0] v, input bit push);
    exp_t e;
    InstHeader = h;
    InstValid  = 1'b1;
    if (push) begin
      e.v = v;
      e.c = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    InstValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  hdr [11];
    logic [21:0] ev  [11];

    hdr[0] = 10'h012; ev[0] = mk(F_IE | F_RW | F_AS, 1, 0, 1);
    hdr[1] = 10'h011; ev[1] = mk(F_IE | F_RW | F_AS, 2, 0, 1);
    hdr[2] = 10'h013; ev[2] = mk(F_IE | F_RW | F_AS, 7, 0, 1);
    hdr[3] = 10'h017; ev[3] = mk(F_RN | F_IE | F_AS, 2, 0, 1);
    hdr[4] = 10'h001; ev[4] = mk(F_RW, 2, 0, 1);
    hdr[5] = 10'h007; ev[5] = mk(F_RS | F_FW, 2, 0, 0);
    hdr[6] = 10'h003; ev[6] = mk(F_RW | F_RS, 8, 0, 1);
    hdr[7] = 10'h020; ev[7] = mk(F_IE | F_RS | F_AS | F_MW, 1, 0, 0);
    hdr[8] = 10'h038; ev[8] = mk(F_IE | F_RS | F_AS | F_RW, 1, 0, 0);
    hdr[9] = 10'h060; ev[9] = mk(0, 0, 0, 0);
    hdr[10] = 10'h005; ev[10] = mk(0, 0, 0, 0);

    idle(2);
    chk("reset_state", {Stall, CtrlValid, PxReq, PxTimeout, obs}, 0);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 11; i++) issue(hdr[i], 1, ev[i], 1);
    chk("no_stall_single", 32'(Stall), 0);
    idle(2);

    issue(10'h2C0, 1, mk(F_IS | F_AS | F_BR, 7, 5, 1), 1);
    idle(2);

    // CUM with a following ADD held by fetch during the stall.
    issue(10'h00B, 4, mk(F_RW | F_RES | F_PAU, 0, 0, 1), 1);
    InstHeader = 10'h012;
    InstValid  = 1'b1;
    begin
      exp_t e;
      e.v = ev[0];
      e.c = cyc + 4;
      q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pau_stall", 32'(Stall), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pau_stall_end", 32'(Stall), 0);
    @(posedge clk);
    #1;
    InstValid = 1'b0;
    idle(2);

    issue(10'h00A, 4, mk(F_RW | F_RES, 0, 0, 1), 1);
    idle(5);

    // LPX acknowledged on the third wait cycle.
    issue(10'h028, 4, mk(F_IO | F_RW, 0, 0, 2), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lpx_req", 32'(PxReq), 1);
      @(posedge clk);
      #1;
    end
    PixelReady = 1'b1;
    @(negedge clk);
    chk("lpx_req_last", 32'(PxReq), 1);
    @(posedge clk);
    #1;
    PixelReady = 1'b0;
    @(negedge clk);
    chk("lpx_req_drop", 32'(PxReq), 0);
    chk("lpx_no_to", 32'(PxTimeout), 0);
    idle(2);

    // SPX never acknowledged: times out after 15 wait cycles, squashed.
    issue(10'h030, 16, mk(F_IO, 0, 0, 0), 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("spx_req", 32'(PxReq), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("spx_req_drop", 32'(PxReq), 0);
    chk("spx_timeout", 32'(PxTimeout), 1);
    @(posedge clk);
    #1;
    PixelReady = 1'b1;
    idle(1);
    PixelReady = 1'b0;
    issue(10'h012, 1, ev[0], 1);
    idle(2);
    chk("timeout_sticky", 32'(PxTimeout), 1);

    // Reset mid PAU_BUSY abandons the op.
    issue(10'h00B, 4, '0, 0);
    idle(1);
    chk("pau_busy", 32'(Stall), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {Stall, CtrlValid, PxReq, PxTimeout, obs}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    chk("post_reset_idle", 32'(Stall), 0);
    chk("drain", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multi-cycle, registered successor to the single-cycle instruction decoder, parametrised in header/field widths and in the PAU and pixel-port latencies.
- Decodes the instruction header into datapath controls and issues them one cycle after acceptance.
- Stalls fetch during multi-cycle PAU ops (AVR/CUM).
- Runs a request/ready handshake with a timeout for pixel-port ops (LPX/SPX), which were previously no-ops.
- Sits between the fetch stage and the datapath.

Parameters:
- HDR_W, 10: header width; the field layout below uses bits [9:0], and bits above 9 are ignored (HDR_W >= 10).
- ALUCTRL_W, 4: ALUControl width (>= 4).
- COND_W, 3: CondFlag width; taken from header [6+COND_W:7].
- PAU_LAT, 4: AVR/CUM latency in cycles (>= 1).
- PX_TIMEOUT, 15: maximum cycles spent waiting for PixelReady (>= 1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- InstHeader, input, HDR_W: instruction header. [9:7] cond; [6:5] class (00 data, 01 mem, 10 branch, 11 nop); [4] imm (data class); [3:0] op (data class); [4:3] mem op.
- InstValid, input, 1: header valid this cycle.
- PixelReady, input, 1: pixel port acknowledge.
- Stall, output, 1: fetch must hold InstHeader/InstValid.
- CtrlValid, output, 1: one-cycle pulse; the control outputs are valid this cycle.
- PxReq, output, 1: pixel port request.
- PxTimeout, output, 1: sticky pixel-timeout error.
- RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite, ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite, output, 1 each: datapath controls.
- ALUControl, output, ALUCTRL_W: ALU operation.
- CondFlag, output, COND_W: branch condition.
- MemToReg, output, 2: writeback source select.

Behaviour:
- Reset (asynchronous, rst_n = 0): every output = 0, state = IDLE, counters = 0, PxTimeout cleared. Reset is the only way to clear PxTimeout. Reset mid-operation abandons the op with no CtrlValid pulse.
- Decode table. Any signal not listed is 0. Any undefined op/class decodes to NOP: all controls 0, CtrlValid still pulses.
  - data imm=1:
    - SUB (op 1): ImmExt, RegWrite, ALUSrc, ALUControl=2, MemToReg=1.
    - ADD (op 2): as SUB but ALUControl=1.
    - MOV (op 3): as SUB but ALUControl=7.
    - CMP (op 7): RnSrc, ImmExt, ALUSrc, ALUControl=2, MemToReg=1.
  - data imm=0:
    - SUB (op 1): RegWrite, ALUControl=2, MemToReg=1.
    - ADD (op 2): RegWrite, ALUControl=1, MemToReg=1.
    - CMP (op 7): RsSrc, FlagWrite, ALUControl=2.
    - MOV (op 3): RegWrite, RsSrc, ALUControl=8, MemToReg=1.
    - AVR (op 10): RegWrite, ResultSrc, MemToReg=1.
    - CUM (op 11): as AVR plus PAUOp.
  - mem:
    - STR (00): ImmExt, RsSrc, ALUSrc, ALUControl=1, MemWrite.
    - LDR (11): ImmExt, RsSrc, ALUSrc, ALUControl=1, RegWrite.
    - LPX (01): IOFlag, RegWrite, MemToReg=2.
    - SPX (10): IOFlag, MemPWrite.
  - branch: ImmSrc, ALUSrc, BranchInst, ALUControl=7, MemToReg=1, CondFlag=header[6+COND_W:7].
- Control outputs are registered and hold their value between pulses. Consumers qualify them with CtrlValid. Stall = (state != IDLE).
- IDLE:
  - InstValid=1 with a single-cycle op: register the controls and pulse CtrlValid on the next cycle (latency 1). Stay in IDLE, so back-to-back issue is possible.
  - AVR/CUM with PAU_LAT > 1: load pau_cnt = PAU_LAT-2 and go to PAU_BUSY. With PAU_LAT = 1 the op is handled as single-cycle.
  - LPX/SPX: register the controls, assert PxReq, load px_cnt = PX_TIMEOUT-1, go to PX_WAIT.
  - PixelReady is ignored in IDLE.
- PAU_BUSY:
  - pau_cnt > 0: decrement.
  - pau_cnt = 0: pulse CtrlValid with the registered controls, return to IDLE.
  - The CtrlValid pulse therefore occurs exactly PAU_LAT cycles after acceptance.
- PX_WAIT (PxReq = 1 throughout):
  - PixelReady = 1: next cycle PxReq = 0, CtrlValid pulses with the registered controls, return to IDLE. PixelReady on the last timeout cycle counts as success.
  - PixelReady = 0 and px_cnt = 0: next cycle PxReq = 0, PxTimeout = 1, CtrlValid pulses with RegWrite = MemPWrite = 0 (squashed), return to IDLE.
  - Otherwise decrement px_cnt.
- InstValid while Stall = 1 is ignored. The header is re-sampled in IDLE after the stall ends.

Test Plan:
- Reset, then InstValid with header 0x012 (ADD imm) -> next cycle CtrlValid=1, RegWrite=1, ALUSrc=1, ImmExt=1, ALUControl=1, MemToReg=1; Stall stays 0.
- Branch header 0x2C0 (cond 101) for one cycle -> CtrlValid pulse, BranchInst=1, CondFlag=5, ALUControl=7.
- CUM (0x00B), PAU_LAT=4 -> Stall=1 for 3 cycles, CtrlValid with PAUOp=1, RegWrite=1 exactly 4 cycles after acceptance; a new InstValid presented during the stall is not decoded until after the pulse.
- LPX (0x028), PixelReady raised 3 cycles later -> PxReq high until ready, CtrlValid with IOFlag=1, RegWrite=1, MemToReg=2 the cycle after; PxTimeout stays 0.
- SPX (0x030), PixelReady never raised, PX_TIMEOUT=15 -> after 15 cycles PxReq=0, PxTimeout=1 and held, squashed CtrlValid with MemPWrite=0; a following ADD issues normally.
- Drop rst_n low mid-PAU_BUSY -> all outputs 0 immediately, no CtrlValid pulse after release, PxTimeout cleared.
